// File: rtl/blink_sched_pkg.sv
// Shared definitions for the blink-code scheduler.
//   state_e   : scheduler FSM states (IDLE, ON, OFF, GAP)
//   hp_cycles : half-period length in clock cycles, clamped to at least 1
//   cnt_w     : bits needed to hold the values 0..max_val (at least 1)
//   idx_w     : bits needed to index n items (at least 1)
package blink_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    function automatic int hp_cycles(input int clk_freq_hz, input int blink_hz);
        int hp;
        hp = clk_freq_hz / (2 * blink_hz);
        return (hp < 1) ? 1 : hp;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blink_code_sched_tick.sv
// Half-period tick generator for the blink-code scheduler.
//   clk     in  : clock
//   rst     in  : asynchronous reset, active-high
//   restart in  : realigns the phase; the next tick arrives HP cycles after this edge
//   tick    out : one-cycle pulse every HP cycles
module blink_tick_gen
    import blink_sched_pkg::*;
#(
    parameter int HP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_w(HP - 1);
    localparam logic [CW-1:0] LAST = CW'(HP - 1);

    logic [CW-1:0] r_cnt;

    // After a restart edge the counter reads 0; it reads HP-1 in the cycle
    // before the edge that lands exactly HP cycles later, which is when the
    // FSM must see the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/blink_code_sched.sv
// Round-robin blink-code scheduler: shares one LED among N_REQ requesters.
// Each requester posts a code c; the granted code plays as c high pulses of
// HP cycles separated by HP-cycle lows, followed by a GAP_HP half-period dark
// gap before the next grant. Code 0 is accepted and discarded.
//   clk        in  : clock
//   rst        in  : asynchronous reset, active-high
//   req_valid  in  : request i pending (held until accepted)
//   req_code   in  : code of requester i at [i*CODE_W +: CODE_W]
//   req_ready  out : one-hot grant, only in IDLE
//   busy       out : high in every state except IDLE
//   active_id  out : index of the last accepted requester
//   q          out : LED drive
//   abort      in  : only when BLINK_SCHED_ABORT_EN is defined; cuts a code
//                    short in ON/OFF and goes straight to a full dark gap
// Handshake: a request transfers on a clk edge where req_valid[i] and
// req_ready[i] are both high; req_ready depends combinationally on req_valid.
module blink_code_sched
    import blink_sched_pkg::*;
#(
    parameter int clk_freq_hz = 1_000_000_000,
    parameter int blink_hz    = 4,
    parameter int N_REQ       = 4,
    parameter int CODE_W      = 4,
    parameter int GAP_HP      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*CODE_W-1:0]   req_code,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      busy,
    output logic [idx_w(N_REQ)-1:0]   active_id,
    output logic                      q
`ifdef BLINK_SCHED_ABORT_EN
    ,
    input  logic                      abort
`endif
);

    localparam int HP    = hp_cycles(clk_freq_hz, blink_hz);
    localparam int PTR_W = idx_w(N_REQ);
    localparam int GAP_W = cnt_w(GAP_HP);
    localparam logic [PTR_W:0]   NREQ_L = (PTR_W + 1)'(N_REQ);
    localparam logic [GAP_W-1:0] GAP_L  = GAP_W'(GAP_HP);

    state_e              r_state;
    logic                r_q;
    logic [CODE_W-1:0]   r_cnt;
    logic [GAP_W-1:0]    r_gap;
    logic [PTR_W-1:0]    r_id;
    logic [PTR_W-1:0]    r_ptr;

    state_e              w_state_nx;
    logic                w_q_nx;
    logic [CODE_W-1:0]   w_cnt_nx;
    logic [GAP_W-1:0]    w_gap_nx;
    logic [PTR_W-1:0]    w_id_nx;
    logic [PTR_W-1:0]    w_ptr_nx;
    logic                w_restart;
    logic                w_tick;
    logic                w_abort;

    logic [PTR_W:0]      w_scan;
    logic                w_found;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [CODE_W-1:0]   w_gnt_code;
    logic [PTR_W:0]      w_ptr_inc;
    logic [PTR_W-1:0]    w_ptr_next;
    logic                w_accept;

`ifdef BLINK_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    blink_tick_gen #(.HP(HP)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Round-robin scan: rr_ptr, rr_ptr+1, ... wrapping at N_REQ. The scan
    // index is one bit wider so the wrap works for non-power-of-two N_REQ.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_scan >= NREQ_L) begin
                w_scan = w_scan - NREQ_L;
            end
            if (!w_found && req_valid[w_scan[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_code = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt_idx == PTR_W'(k)) begin
                w_gnt_code = req_code[k*CODE_W +: CODE_W];
            end
        end
        w_ptr_inc  = {1'b0, w_gnt_idx} + (PTR_W + 1)'(1);
        w_ptr_next = (w_ptr_inc == NREQ_L) ? '0 : w_ptr_inc[PTR_W-1:0];
    end

    assign w_accept = (r_state == IDLE) && w_found;

    // Gated with rst so the grant drops the instant reset is asserted,
    // not just once the state register has cleared.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = w_accept && !rst && (w_gnt_idx == PTR_W'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= 1'b0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_cnt   <= w_cnt_nx;
            r_gap   <= w_gap_nx;
            r_id    <= w_id_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_cnt_nx   = r_cnt;
        w_gap_nx   = r_gap;
        w_id_nx    = r_id;
        w_ptr_nx   = r_ptr;
        w_restart  = 1'b0;

        if ((r_state == ON || r_state == OFF) && w_abort) begin
            // Abort wins over a coincident tick; restarting the tick keeps
            // the dark gap at its full GAP_HP half periods.
            w_state_nx = GAP;
            w_q_nx     = 1'b0;
            w_cnt_nx   = '0;
            w_gap_nx   = GAP_L;
            w_restart  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_id_nx   = w_gnt_idx;
                        w_ptr_nx  = w_ptr_next;
                        w_cnt_nx  = w_gnt_code;
                        w_restart = 1'b1;
                        if (w_gnt_code != '0) begin
                            w_state_nx = ON;
                            w_q_nx     = 1'b1;
                        end
                    end
                end
                ON: begin
                    if (w_tick) begin
                        w_q_nx     = 1'b0;
                        w_cnt_nx   = r_cnt - CODE_W'(1);
                        w_state_nx = OFF;
                    end
                end
                OFF: begin
                    if (w_tick) begin
                        if (r_cnt != '0) begin
                            w_q_nx     = 1'b1;
                            w_state_nx = ON;
                        end else begin
                            w_gap_nx   = GAP_L;
                            w_state_nx = GAP;
                        end
                    end
                end
                GAP: begin
                    w_q_nx = 1'b0;
                    if (w_tick) begin
                        // The tick that empties the counter ends the gap.
                        if (r_gap <= GAP_W'(1)) begin
                            w_gap_nx   = '0;
                            w_state_nx = IDLE;
                        end else begin
                            w_gap_nx = r_gap - GAP_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_q_nx     = 1'b0;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign active_id = r_id;
    assign q         = r_q;

endmodule
